uart_rx_poller: RTL and testbench
=================================

Name: uart_rx_poller

Overview:
- AXI4-Lite read master that sits beside the transmit path on the same axi_uartlite_0 instance and drains its receive side.
- Polls the uartlite STAT register (0x8) and reads the RX FIFO register (0x0) whenever data is present.
- Buffers received bytes in a local FIFO and presents them downstream on a valid/ready byte stream, for example to the ESP32 response parser.
- Counts line errors and AXI error responses.

Parameters:
DEPTH, 16, local byte FIFO depth; must be a power of two, 2..256
POLL_GAP, 4, idle clocks between an empty-status poll and the next poll
STAT_ADDR, 4'h8, uartlite status register address
RXF_ADDR, 4'h0, uartlite RX FIFO register address

Ports:
clk  in  1  system clock
rst  in  1  reset
araddr  out  4  AXI read address
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
rdata  in  32  AXI read data
rresp  in  2  AXI read response
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready
data  out  8  received byte, head of local FIFO
valid  out  1  data is valid
ready  in  1  downstream accepts data
count  out  $clog2(DEPTH)+1  local FIFO occupancy
err_count  out  8  saturating count of line/AXI errors
overrun  out  1  sticky; set when a uartlite overrun is reported

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: arvalid=0, rready=0, araddr=0, valid=0, count=0, err_count=0, overrun=0, FIFO pointers=0, gap counter=0, state=IDLE.
- Reset mid-transaction abandons the AXI transfer immediately. The uartlite is reset by the same signal, so no cleanup is required.
- All outputs are registered.
- State machine:
  - IDLE: leave when the gap counter is 0 and count < DEPTH, going to S_AR. Otherwise decrement the gap counter if it is nonzero.
  - S_AR: araddr=STAT_ADDR, arvalid=1. arvalid is held until an arready handshake, then arvalid=0 and go to S_R.
  - S_R: rready=1. On rvalid, capture the status word:
    - bit5 (overrun) sets overrun and increments err_count.
    - bit6 (frame) and bit7 (parity) each add 1 to err_count; both set adds 2.
    - If rresp != 0: err_count+1, then IDLE with gap = POLL_GAP.
    - Else if bit0 (RX valid data): go to D_AR.
    - Else: go to IDLE with gap = POLL_GAP.
  - D_AR: araddr=RXF_ADDR, arvalid=1. On arready go to D_R.
  - D_R: rready=1. On rvalid:
    - If rresp == 0, push rdata[7:0] into the FIFO. Otherwise discard the byte and add 1 to err_count.
    - Then go to S_AR with no gap if post-push count < DEPTH (burst drain). Otherwise go to IDLE.
- At most one outstanding read. arvalid and rready are never asserted together. araddr is stable while arvalid is high.
- Only DATA_R issues a push, and only when count < DEPTH was true at S_AR entry and no pop could reduce the space. The FIFO therefore never overflows. This is a design invariant; the bench asserts it.
- FIFO:
  - First-word-fall-through: valid = (count != 0), data = mem[rd_ptr].
  - Pop when valid && ready.
  - Push and pop in the same cycle leave count unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Push-to-valid latency is 1 clock: the byte is visible the cycle after the rvalid handshake.
- err_count saturates at 8'hFF and never wraps.
- overrun clears only on rst.

Test Plan:
- Empty uartlite (STAT=0x04 returned) -> reads alternate to 0x8 only, separated by exactly POLL_GAP+1 idle clocks. No pushes; valid stays 0.
- RX holds 3 bytes 0x41,0x54,0x0D with ready=1 -> read sequence 8,0,8,0,8,0,8 with no gap between them. Downstream sees 0x41,0x54,0x0D in order, each 1 clock after its rvalid. Then polling resumes with the gap.
- ready=0 with 20 bytes available in the uartlite model -> exactly DEPTH=16 bytes read and count=16. No further arvalid until ready pulses once. Then exactly one more status/data read occurs.
- STAT=0xE1 (valid data plus overrun, frame and parity) -> err_count=3, overrun=1, data byte still read and pushed. Repeat 90 times -> err_count saturates at 8'hFF.
- rresp=2'b10 on a data read -> byte not pushed, err_count+1, next action is a status read.
- Assert rst while arvalid=1 in D_AR, with 5 bytes buffered -> next cycle arvalid=0, count=0, valid=0, state=IDLE. Normal polling resumes after release.

Source files
------------

// File: rtl/uart_rx_poller.sv
// AXI4-Lite read master that polls an axi_uartlite status register, drains its
// RX FIFO into a local first-word-fall-through byte FIFO and counts line/AXI errors.
module uart_rx_poller #(
    parameter int         DEPTH     = 16,
    parameter int         POLL_GAP  = 4,
    parameter logic [3:0] STAT_ADDR = 4'h8,
    parameter logic [3:0] RXF_ADDR  = 4'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [3:0]               araddr,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [7:0]               data,
    output logic                     valid,
    input  logic                     ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               err_count,
    output logic                     overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {IDLE, S_AR, S_R, D_AR, D_R} state_t;

    state_t          state_q;
    logic [GW-1:0]   gap_q;
    logic [3:0]      araddr_q;
    logic            arvalid_q;
    logic            rready_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW-1:0]   wr_ptr_d, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q;
    logic [7:0]      data_q, data_d;
    logic [7:0]      err_q, err_d;
    logic            ovr_q;
    logic [7:0]      mem [DEPTH];

    logic            stat_hs, data_hs, push, pop;
    logic [2:0]      err_inc;
    logic [8:0]      err_sum;
    logic            unused_rdata;

    assign unused_rdata = ^rdata[31:8];

    assign stat_hs = (state_q == S_R) && rready_q && rvalid;
    assign data_hs = (state_q == D_R) && rready_q && rvalid;
    assign push    = data_hs && (rresp == 2'b00);
    assign pop     = valid_q && ready;

    assign wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    assign count_d  = count_q + CW'(push) - CW'(pop);

    // Head register looks ahead one cycle; a byte written into the slot that
    // becomes the head must bypass the memory.
    assign data_d = (push && (wr_ptr_q == rd_ptr_d)) ? rdata[7:0] : mem[rd_ptr_d];

    always_comb begin
        err_inc = 3'd0;
        if (stat_hs)
            err_inc = 3'(rdata[5]) + 3'(rdata[6]) + 3'(rdata[7]) + 3'(rresp != 2'b00);
        else if (data_hs && (rresp != 2'b00))
            err_inc = 3'd1;
    end

    assign err_sum = {1'b0, err_q} + 9'(err_inc);
    assign err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= rdata[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= 8'h00;
            err_q    <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            araddr_q  <= 4'h0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((gap_q == '0) && (count_q < CW'(DEPTH))) begin
                        state_q   <= S_AR;
                        araddr_q  <= STAT_ADDR;
                        arvalid_q <= 1'b1;
                    end else if (gap_q != '0) begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        if (rdata[5])
                            ovr_q <= 1'b1;
                        if ((rresp != 2'b00) || !rdata[0]) begin
                            state_q <= IDLE;
                            gap_q   <= GW'(POLL_GAP);
                        end else begin
                            state_q   <= D_AR;
                            araddr_q  <= RXF_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                D_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= D_R;
                    end
                end
                D_R: begin
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        // Keep draining back-to-back while the local FIFO has room.
                        if (count_d < CW'(DEPTH)) begin
                            state_q   <= S_AR;
                            araddr_q  <= STAT_ADDR;
                            arvalid_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign araddr    = araddr_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign data      = data_q;
    assign valid     = valid_q;
    assign count     = count_q;
    assign err_count = err_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_poller.sv
// Bench for uart_rx_poller: behavioural uartlite read slave, expected-byte
// scoreboard drained by a monitor, plus directed checks of reads and counters.
module tb_uart_rx_poller;

    localparam int DEPTH    = 16;
    localparam int POLL_GAP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [7:0]  data;
    logic        valid, ready;
    logic [4:0]  count;
    logic [7:0]  err_count;
    logic        overrun;

    uart_rx_poller #(.DEPTH(DEPTH), .POLL_GAP(POLL_GAP), .STAT_ADDR(4'h8), .RXF_ADDR(4'h0)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .data(data), .valid(valid), .ready(ready),
        .count(count), .err_count(err_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [3:0] addr_log[$];
    int         cyc_log[$];
    logic [7:0] stat_flags = 8'h00;
    bit         derr_once = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        int k = 0;
        while (addr_log.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        ok = (addr_log.size() >= n);
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_log: got %0d reads, expected %0d", addr_log.size(), n);
        end
    endtask

    task automatic wait_quiet();
        int k = 0;
        @(posedge clk); #1;
        while ((arvalid || rready) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (arvalid || rready) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_quiet: bus still busy, got arvalid=%0b rready=%0b, expected 0/0", arvalid, rready);
        end
    endtask

    task automatic wait_drained(input int budget);
        int k = 0;
        while ((rx_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (10) @(posedge clk);
        check("drain_rx", rx_q.size(), 0);
        check("drain_sb", exp_q.size(), 0);
    endtask

    // uartlite read slave: one-cycle arready, read data the following cycle.
    initial begin
        logic [3:0] a;
        bit pend, lastd;
        pend = 0; lastd = 0; a = 4'h0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0; lastd = 0; arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
            end else begin
                if (rvalid) begin
                    rvalid = 1'b0;
                    rresp  = 2'b00;
                    if (lastd) check("push_to_valid", valid, 1);
                    lastd = 0;
                end
                if (pend) begin
                    arready = 1'b0;
                    pend    = 0;
                    rvalid  = 1'b1;
                    rresp   = 2'b00;
                    if (a == 4'h8) begin
                        rdata = {24'h0, (rx_q.size() != 0) ? (stat_flags | 8'h05) : 8'h04};
                    end else begin
                        rdata = 32'h0;
                        if (rx_q.size() != 0) rdata[7:0] = rx_q.pop_front();
                        if (derr_once) begin
                            rresp = 2'b10;
                            derr_once = 1'b0;
                        end
                        lastd = (rresp == 2'b00);
                    end
                end else if (arvalid) begin
                    arready = 1'b1;
                    pend    = 1;
                    a       = araddr;
                    addr_log.push_back(araddr);
                    cyc_log.push_back(cyc);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted byte, watches bus invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (arvalid && rready) begin
                    miscompares++;
                    $display("FAIL bus_overlap: got arvalid=1 rready=1, expected never both");
                end
                if (count > DEPTH) begin
                    miscompares++;
                    $display("FAIL fifo_overflow: got count=%0d, expected <= %0d", count, DEPTH);
                end
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL data_unexpected: got 0x%0h, expected no byte", data);
                    end else begin
                        check("data", data, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int  mark, base;
        bit  ok;
        logic [3:0] burst_exp [8];
        burst_exp = '{4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h8};
        rst = 1'b1; ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_araddr", araddr, 0);
        check("rst_valid", valid, 0);
        check("rst_count", count, 0);
        check("rst_err", err_count, 0);
        check("rst_overrun", overrun, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Empty uartlite: status-only polls, POLL_GAP+1 idle clocks apart.
        wait_log(5, 200, ok);
        if (ok) begin
            for (int i = 1; i < 5; i++) begin
                check("empty_addr", addr_log[i], 4'h8);
                check("empty_spacing", cyc_log[i] - cyc_log[i-1], POLL_GAP + 3);
            end
        end
        check("empty_valid", valid, 0);

        // Three-byte burst drain with no gap between reads.
        wait_quiet();
        mark = addr_log.size();
        rx_q.push_back(8'h41); rx_q.push_back(8'h54); rx_q.push_back(8'h0D);
        exp_q.push_back(8'h41); exp_q.push_back(8'h54); exp_q.push_back(8'h0D);
        wait_log(mark + 8, 300, ok);
        if (ok) begin
            for (int i = 0; i < 8; i++) check("burst_addr", addr_log[mark+i], burst_exp[i]);
            for (int i = 1; i < 7; i++) check("burst_spacing", cyc_log[mark+i] - cyc_log[mark+i-1], 2);
            check("burst_resume_gap", cyc_log[mark+7] - cyc_log[mark+6], POLL_GAP + 3);
        end
        wait_drained(100);

        // Backpressure: FIFO fills to DEPTH, polling stops until one pop.
        @(posedge clk); #1 ready = 1'b0;
        wait_quiet();
        mark = addr_log.size();
        for (int i = 0; i < 20; i++) begin
            rx_q.push_back(8'(8'h80 + i));
            exp_q.push_back(8'(8'h80 + i));
        end
        repeat (150) @(posedge clk);
        #1;
        check("full_count", count, DEPTH);
        check("full_valid", valid, 1);
        check("full_head", data, 8'h80);
        check("full_reads", addr_log.size() - mark, 2 * DEPTH);
        check("full_rx_left", rx_q.size(), 4);
        base = addr_log.size();
        repeat (30) @(posedge clk);
        check("full_stalled", addr_log.size(), base);
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("pulse_reads", addr_log.size() - base, 2);
        if (addr_log.size() >= base + 2) begin
            check("pulse_addr0", addr_log[base], 4'h8);
            check("pulse_addr1", addr_log[base+1], 4'h0);
        end
        check("pulse_count", count, DEPTH);
        @(posedge clk); #1 ready = 1'b1;
        wait_drained(300);

        // AXI error on a data read: byte dropped, status read follows.
        wait_quiet();
        mark = addr_log.size();
        derr_once = 1'b1;
        rx_q.push_back(8'h11); rx_q.push_back(8'h22);
        exp_q.push_back(8'h22);
        wait_log(mark + 5, 200, ok);
        if (ok) begin
            check("derr_addr_data", addr_log[mark+1], 4'h0);
            check("derr_addr_next", addr_log[mark+2], 4'h8);
        end
        wait_drained(100);
        check("derr_err", err_count, 1);
        check("derr_overrun", overrun, 0);

        // Overrun+frame+parity status on every data-present poll; saturation.
        wait_quiet();
        stat_flags = 8'hE0;
        rx_q.push_back(8'h5A); exp_q.push_back(8'h5A);
        wait_drained(100);
        check("lerr_err", err_count, 4);
        check("lerr_overrun", overrun, 1);
        for (int i = 0; i < 89; i++) begin
            rx_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        wait_drained(1500);
        check("lerr_saturate", err_count, 8'hFF);
        check("lerr_overrun_sticky", overrun, 1);
        stat_flags = 8'h00;

        // Reset while a data read address is pending with 5 bytes buffered.
        @(posedge clk); #1 ready = 1'b0;
        wait_quiet();
        for (int i = 0; i < 5; i++) begin
            rx_q.push_back(8'(8'h31 + i));
            exp_q.push_back(8'(8'h31 + i));
        end
        begin
            int k = 0;
            while (count != 5 && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
        end
        check("pre_rst_count", count, 5);
        wait_quiet();
        rx_q.push_back(8'h36);
        begin
            int k = 0;
            while (!(arvalid && araddr == 4'h0) && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
        end
        check("pre_rst_arvalid", arvalid, 1);
        rst = 1'b1;
        exp_q.delete();
        rx_q.delete();
        @(negedge clk);
        check("mid_rst_arvalid", arvalid, 0);
        check("mid_rst_rready", rready, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_err", err_count, 0);
        check("mid_rst_overrun", overrun, 0);
        @(posedge clk); #1;
        ready = 1'b1;
        mark = addr_log.size();
        rx_q.push_back(8'h77); exp_q.push_back(8'h77);
        rst = 1'b0;
        wait_log(mark + 2, 50, ok);
        if (ok) begin
            check("post_rst_addr0", addr_log[mark], 4'h8);
            check("post_rst_addr1", addr_log[mark+1], 4'h0);
        end
        wait_drained(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
